// File: rtl/sample_framer_if.sv
// rtl/sample_framer_if.sv - sample input and byte transmitter handshake bundle
interface sample_framer_if;
  logic        sample_valid;
  logic [15:0] sample_data;
  logic        sample_ready;
  logic        rdy;
  logic        wrreq;
  logic [7:0]  wdata;
  logic        frame_done;

  // Upstream sample source and byte transmitter side
  modport master (
    output sample_valid, sample_data, rdy,
    input  sample_ready, wrreq, wdata, frame_done
  );

  // Framer side
  modport slave (
    input  sample_valid, sample_data, rdy,
    output sample_ready, wrreq, wdata, frame_done
  );
endinterface

// File: rtl/sample_framer.sv
// rtl/sample_framer.sv - buffers 16-bit samples and emits 5-byte framed packets
module sample_framer #(
  parameter int         DEPTH  = 4,
  parameter logic [7:0] HEADER = 8'hA5
) (
  input  logic           clk,
  input  logic           nrst,
  sample_framer_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_LOW, WAIT_HI} state_t;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop, empty;

  state_t      state, state_n;
  logic [2:0]  idx, idx_n;
  logic [15:0] frame, frame_n;
  logic [7:0]  csum, csum_n;
  logic [7:0]  seq, seq_n;
  logic        wrreq_q, wrreq_n;
  logic [7:0]  wdata_q, wdata_n;
  logic        done_q, done_n;
  logic [7:0]  cur_byte;

  // Ready comes only from registered occupancy, so a same-cycle pop never lets a full FIFO accept
  assign bus.sample_ready = (count != CNT_FULL);
  assign empty            = (count == '0);
  assign push             = bus.sample_valid & bus.sample_ready;

  assign bus.wrreq      = wrreq_q;
  assign bus.wdata      = wdata_q;
  assign bus.frame_done = done_q;

  // Sample storage; contents need no reset because occupancy gates every read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.sample_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Select the outgoing byte for the current frame position
  always_comb begin
    cur_byte = HEADER;
    case (idx)
      3'd0:    cur_byte = HEADER;
      3'd1:    cur_byte = seq;
      3'd2:    cur_byte = frame[15:8];
      3'd3:    cur_byte = frame[7:0];
      default: cur_byte = csum;
    endcase
  end

  // Framer FSM and all registered outputs
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state   <= IDLE;
      idx     <= 3'd0;
      frame   <= 16'h0000;
      csum    <= 8'h00;
      seq     <= 8'h00;
      wrreq_q <= 1'b0;
      wdata_q <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      frame   <= frame_n;
      csum    <= csum_n;
      seq     <= seq_n;
      wrreq_q <= wrreq_n;
      wdata_q <= wdata_n;
      done_q  <= done_n;
    end
  end

  // Next-state logic; the head sample is popped only when starting a frame from IDLE
  always_comb begin
    state_n = state;
    idx_n   = idx;
    frame_n = frame;
    csum_n  = csum;
    seq_n   = seq;
    wrreq_n = 1'b0;
    wdata_n = wdata_q;
    done_n  = 1'b0;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          frame_n = mem[rd_ptr];
          idx_n   = 3'd0;
          state_n = LOAD;
        end
      end
      LOAD: begin
        csum_n  = seq + frame[15:8] + frame[7:0];
        state_n = SEND;
      end
      SEND: begin
        if (bus.rdy) begin
          wrreq_n = 1'b1;
          wdata_n = cur_byte;
          state_n = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        // The transmitter drops rdy one cycle after seeing wrreq
        if (!bus.rdy) state_n = WAIT_HI;
      end
      WAIT_HI: begin
        if (bus.rdy) begin
          if (idx == 3'd4) begin
            done_n  = 1'b1;
            seq_n   = seq + 8'd1;
            state_n = IDLE;
          end else begin
            idx_n   = idx + 3'd1;
            state_n = SEND;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
